// File: rtl/tlb.sv
// Fully-associative TLB for a single requester. Hits return the translation
// combinationally; a miss holds one walker request until it responds, then
// valid translations are filled round-robin and faults are returned uncached.
module tlb #(
  parameter int unsigned ENTRIES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lookup_valid,
  input  logic [63:0] lookup_addr,
  output logic        lookup_resp_valid,
  output logic [63:0] lookup_paddr,
  output logic [7:0]  lookup_perms,
  output logic        lookup_fault,
  output logic        mmu_req_valid,
  output logic [63:0] mmu_req_addr,
  input  logic        mmu_resp_valid,
  input  logic [63:0] mmu_resp_addr,
  input  logic [7:0]  mmu_resp_perms,
  input  logic        flush,
  input  logic [63:0] root_pt_addr
);

  localparam int unsigned PtrW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  state_e              state_q, state_d;
  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [51:0]         tag_q   [ENTRIES];
  logic [51:0]         ppn_q   [ENTRIES];
  logic [7:0]          perms_q [ENTRIES];
  logic [PtrW-1:0]     repl_ptr_q, repl_ptr_d;
  logic                kill_q, kill_d;
  logic [63:0]         miss_addr_q, miss_addr_d;
  logic [63:0]         root_q;
  logic [51:0]         resp_ppn_q;
  logic [7:0]          resp_perms_q;

  logic                inval;
  logic                fill;
  logic                capture;
  logic                hit;
  logic [51:0]         hit_ppn;
  logic [7:0]          hit_perms;

  // Page-offset bits of the walker address carry no information.
  logic unused_resp_offset;
  assign unused_resp_offset = ^mmu_resp_addr[11:0];

  // A root change is detected against last cycle's root, so it acts like a flush pulse.
  assign inval = flush || (root_pt_addr != root_q);

  // Tag match; tags are unique so OR-combining the matching entry is a mux.
  always_comb begin
    hit       = 1'b0;
    hit_ppn   = '0;
    hit_perms = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (tag_q[i] == lookup_addr[63:12])) begin
        hit       = 1'b1;
        hit_ppn   = hit_ppn | ppn_q[i];
        hit_perms = hit_perms | perms_q[i];
      end
    end
  end

  // Next-state, fill decision and requester/walker outputs.
  always_comb begin
    state_d           = state_q;
    miss_addr_d       = miss_addr_q;
    kill_d            = kill_q;
    fill              = 1'b0;
    capture           = 1'b0;
    lookup_resp_valid = 1'b0;
    lookup_paddr      = '0;
    lookup_perms      = '0;
    lookup_fault      = 1'b0;
    mmu_req_valid     = 1'b0;
    mmu_req_addr      = '0;

    unique case (state_q)
      StIdle: begin
        if (lookup_valid) begin
          if (hit) begin
            lookup_resp_valid = 1'b1;
            lookup_paddr      = {hit_ppn, lookup_addr[11:0]};
            lookup_perms      = hit_perms;
          end else begin
            miss_addr_d = lookup_addr;
            state_d     = StWait;
          end
        end
      end
      StWait: begin
        mmu_req_valid = 1'b1;
        mmu_req_addr  = miss_addr_q;
        if (inval) begin
          kill_d = 1'b1;
        end
        if (mmu_resp_valid) begin
          capture = 1'b1;
          state_d = StResp;
          // An invalidation on the same edge also suppresses the fill.
          fill    = mmu_resp_perms[0] && !kill_q && !inval;
        end
      end
      StResp: begin
        state_d = StIdle;
        kill_d  = 1'b0;
        if (lookup_valid && !kill_q && (lookup_addr[63:12] == miss_addr_q[63:12])) begin
          lookup_resp_valid = 1'b1;
          lookup_perms      = resp_perms_q;
          if (resp_perms_q[0]) begin
            lookup_paddr = {resp_ppn_q, lookup_addr[11:0]};
          end else begin
            lookup_fault = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Valid bits and replacement pointer; invalidation overrides a fill.
  always_comb begin
    valid_d    = valid_q;
    repl_ptr_d = repl_ptr_q;
    if (fill) begin
      valid_d[repl_ptr_q] = 1'b1;
      repl_ptr_d          = repl_ptr_q + PtrW'(1);
    end
    if (inval) begin
      valid_d = '0;
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      repl_ptr_q   <= '0;
      kill_q       <= 1'b0;
      miss_addr_q  <= '0;
      root_q       <= root_pt_addr;
      resp_ppn_q   <= '0;
      resp_perms_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      repl_ptr_q  <= repl_ptr_d;
      kill_q      <= kill_d;
      miss_addr_q <= miss_addr_d;
      root_q      <= root_pt_addr;
      if (capture) begin
        resp_ppn_q   <= mmu_resp_addr[63:12];
        resp_perms_q <= mmu_resp_perms;
      end
    end
  end

  // Entry payload; qualified by valid_q so it needs no reset.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[repl_ptr_q]   <= miss_addr_q[63:12];
      ppn_q[repl_ptr_q]   <= mmu_resp_addr[63:12];
      perms_q[repl_ptr_q] <= mmu_resp_perms;
    end
  end

endmodule
